// File: rtl/bias_sweep_ctrl_if.sv
// Handshake bundle between the bias sweep controller, the noise detector and
// the SPI DAC driver.
//  master : the controller (drives dac_code/spi_start and status)
//  slave  : the surroundings (drive start/abort/noise_valid/spi_done)
interface bias_sweep_ctrl_if #(
  parameter int DAC_W = 8
);
  logic             start;
  logic             abort;
  logic             noise_valid;
  logic             spi_done;
  logic [DAC_W-1:0] dac_code;
  logic             spi_start;
  logic             busy;
  logic             locked;
  logic             fail;
  logic [DAC_W-1:0] lock_code;
  logic [2:0]       dbg_state;
  logic [3:0]       dbg_win;

  modport master (
    input  start, abort, noise_valid, spi_done,
    output dac_code, spi_start, busy, locked, fail, lock_code, dbg_state, dbg_win
  );

  modport slave (
    output start, abort, noise_valid, spi_done,
    input  dac_code, spi_start, busy, locked, fail, lock_code, dbg_state, dbg_win
  );
endinterface

// File: rtl/bias_sweep_ctrl.sv
// Diode bias sweep controller.
// Ramps a DAC code (coarse steps, then fine steps after a back-off) through an
// SPI DAC, waits for the write to complete, settles, skips a dead gap and then
// listens for noise. Locks once N_WIN consecutive noisy windows are seen at one
// code; fails on SPI timeout or when the next step would exceed MAX_CODE.
// Ports:
//  clk, reset_n : clock (rising edge), asynchronous active-low reset
//  bus (master) : start/abort/noise_valid/spi_done in;
//                 dac_code/spi_start/busy/locked/fail/lock_code/dbg_* out
module bias_sweep_ctrl #(
  parameter int DAC_W       = 8,
  parameter int START_CODE  = 0,
  parameter int MAX_CODE    = 255,
  parameter int COARSE_STEP = 4,
  parameter int FINE_STEP   = 1,
  parameter int BACKOFF     = 4,
  parameter int FINE_EN     = 1,
  parameter int N_WIN       = 3,
  parameter int T_SETTLE    = 17500,
  parameter int T_GAP       = 250,
  parameter int T_LISTEN    = 5750,
  parameter int SPI_TO      = 1500
) (
  input logic               clk,
  input logic               reset_n,
  bias_sweep_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_GAP    = 3'd3,
    S_LISTEN = 3'd4,
    S_DECIDE = 3'd5,
    S_LOCKED = 3'd6,
    S_FAIL   = 3'd7
  } state_t;

  typedef enum logic {PH_COARSE = 1'b0, PH_FINE = 1'b1} phase_t;

  // One shared timer serves every timed state; it only has to reach the
  // longest duration minus one.
  localparam int T_A   = (T_SETTLE > T_GAP) ? T_SETTLE : T_GAP;
  localparam int T_B   = (T_LISTEN > SPI_TO) ? T_LISTEN : SPI_TO;
  localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int SW    = DAC_W + 1;
  // Without the fine search the controller lives in the fine phase forever.
  localparam phase_t PH_RST = (FINE_EN != 0) ? PH_COARSE : PH_FINE;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [DAC_W-1:0] code_q,  code_d;
  logic [DAC_W-1:0] lock_q,  lock_d;
  logic [3:0]       win_q,   win_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             noisy_q, noisy_d;

  logic [SW-1:0]    step_x, sum_x;
  logic [3:0]       win_inc;

  // Step sum is one bit wider so an overshoot past MAX_CODE is visible
  // instead of wrapping.
  assign step_x  = (phase_q == PH_FINE) ? SW'(FINE_STEP) : SW'(COARSE_STEP);
  assign sum_x   = {1'b0, code_q} + step_x;
  assign win_inc = win_q + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      phase_q <= PH_RST;
      code_q  <= '0;
      lock_q  <= '0;
      win_q   <= '0;
      timer_q <= '0;
      noisy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      code_q  <= code_d;
      lock_q  <= lock_d;
      win_q   <= win_d;
      timer_q <= timer_d;
      noisy_q <= noisy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    code_d  = code_q;
    lock_d  = lock_q;
    win_d   = win_q;
    timer_d = '0;          // every state transition clears the timer
    noisy_d = noisy_q;
    if (bus.abort) begin
      // Codes are kept so a host can inspect where the sweep stopped.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_LOCKED, S_FAIL: begin
          if (bus.start) begin
            state_d = S_LOAD;
            code_d  = DAC_W'(START_CODE);
            win_d   = '0;
            phase_d = PH_RST;
          end
        end
        S_LOAD: begin
          // spi_done wins over the timeout on the last allowed cycle.
          if (bus.spi_done)                       state_d = S_SETTLE;
          else if (timer_q == TW'(SPI_TO - 1))    state_d = S_FAIL;
          else                                    timer_d = timer_q + TW'(1);
        end
        S_SETTLE: begin
          if (timer_q == TW'(T_SETTLE - 1)) state_d = S_GAP;
          else                              timer_d = timer_q + TW'(1);
        end
        S_GAP: begin
          if (timer_q == TW'(T_GAP - 1)) begin
            state_d = S_LISTEN;
            noisy_d = 1'b0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_LISTEN: begin
          noisy_d = noisy_q | bus.noise_valid;
          if (timer_q == TW'(T_LISTEN - 1)) state_d = S_DECIDE;
          else                              timer_d = timer_q + TW'(1);
        end
        S_DECIDE: begin
          if (noisy_q && phase_q == PH_COARSE && FINE_EN != 0) begin
            // First noise in coarse search: step back and refine.
            code_d  = (int'(code_q) < START_CODE + BACKOFF) ? DAC_W'(START_CODE)
                                                            : code_q - DAC_W'(BACKOFF);
            phase_d = PH_FINE;
            win_d   = '0;
            state_d = S_LOAD;
          end else if (noisy_q) begin
            win_d = win_inc;
            if (win_inc == 4'(N_WIN)) begin
              lock_d  = code_q;
              state_d = S_LOCKED;
            end else begin
              state_d = S_LOAD;  // retry the same code, rewrites the DAC
            end
          end else begin
            win_d = '0;
            if (sum_x > SW'(MAX_CODE)) begin
              state_d = S_FAIL;
            end else begin
              code_d  = sum_x[DAC_W-1:0];
              state_d = S_LOAD;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The timer is zero only on the first LOAD cycle, which is the write pulse.
  assign bus.spi_start = (state_q == S_LOAD) && (timer_q == '0);
  assign bus.busy      = state_q inside {S_LOAD, S_SETTLE, S_GAP, S_LISTEN, S_DECIDE};
  assign bus.locked    = (state_q == S_LOCKED);
  assign bus.fail      = (state_q == S_FAIL);
  assign bus.dac_code  = code_q;
  assign bus.lock_code = lock_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_win   = win_q;

endmodule
